// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a direct-select mode and a self-scanning mode
// that walks outputs 0..last, holding each index for dwell+1 cycles.
module scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    g_i,
  input  logic                    mode_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [SEL_W-1:0]        last_i,
  input  logic [DWELL_W-1:0]      dwell_i,
  output logic [(1<<SEL_W)-1:0]   y_o,
  output logic [SEL_W-1:0]        idx_o,
  output logic                    valid_o,
  output logic                    wrap_o
);

  localparam int OUT_N = 1 << SEL_W;
  localparam logic [OUT_N-1:0] Y_INACTIVE = {OUT_N{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [OUT_N-1:0]     y_q, y_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 wrap_q, wrap_d;

  function automatic logic [OUT_N-1:0] decode(input logic [SEL_W-1:0] idx);
    logic [OUT_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return ACTIVE_LOW ? ~oh : oh;
  endfunction

  always_comb begin
    state_d = IDLE;
    idx_d   = '0;
    cnt_d   = '0;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (!g_i) begin
      valid_d = 1'b1;
      if (!mode_i) begin
        state_d = DIRECT;
        idx_d   = sel_i;
      end else begin
        state_d = SCAN;
        if (state_q != SCAN) begin
          // fresh entry always starts at index 0 with a freshly sampled dwell
          cnt_d = dwell_i;
        end else if (cnt_q != '0) begin
          idx_d = idx_q;
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          cnt_d = dwell_i;
          if (idx_q >= last_i) begin
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end
      end
    end
    y_d = valid_d ? decode(idx_d) : Y_INACTIVE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      y_q     <= Y_INACTIVE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y_o     = y_q;
  assign idx_o   = idx_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: vector table for reset/direct/idle, plus
// hand-written scan sequences and a 4-bit active-high instance.
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, g, mode;
  logic [2:0] sel, last;
  logic [7:0] dwell;
  logic [7:0] y;
  logic [2:0] idx;
  logic       valid, wrap;

  logic        rst16, g16, mode16;
  logic [3:0]  sel16, last16;
  logic [7:0]  dwell16;
  logic [15:0] y16;
  logic [3:0]  idx16;
  logic        valid16, wrap16;

  int tests = 0;
  int fails = 0;

  scan_decoder #(.SEL_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .g_i(g), .mode_i(mode), .sel_i(sel),
    .last_i(last), .dwell_i(dwell), .y_o(y), .idx_o(idx),
    .valid_o(valid), .wrap_o(wrap)
  );

  scan_decoder #(.SEL_W(4), .DWELL_W(8), .ACTIVE_LOW(1'b0)) u_dut16 (
    .clk_i(clk), .rst_i(rst16), .g_i(g16), .mode_i(mode16), .sel_i(sel16),
    .last_i(last16), .dwell_i(dwell16), .y_o(y16), .idx_o(idx16),
    .valid_o(valid16), .wrap_o(wrap16)
  );

  typedef struct {
    logic       rst, g, mode;
    logic [2:0] sel, last;
    logic [7:0] dwell;
    logic [7:0] ey;
    logic [2:0] eidx;
    logic       evalid, ewrap;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string nm, input logic [7:0] ey, input logic [2:0] ei,
                      input logic ev, input logic ew);
    tests++;
    if ({y, idx, valid, wrap} !== {ey, ei, ev, ew}) begin
      fails++;
      $display("FAIL %s: got y=%h idx=%0d valid=%b wrap=%b, expected y=%h idx=%0d valid=%b wrap=%b",
               nm, y, idx, valid, wrap, ey, ei, ev, ew);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] ey, input logic [3:0] ei,
                       input logic ev, input logic ew);
    tests++;
    if ({y16, idx16, valid16, wrap16} !== {ey, ei, ev, ew}) begin
      fails++;
      $display("FAIL %s: got y=%h idx=%0d valid=%b wrap=%b, expected y=%h idx=%0d valid=%b wrap=%b",
               nm, y16, idx16, valid16, wrap16, ey, ei, ev, ew);
    end
  endtask

  function automatic logic [7:0] al8(input int i);
    logic [7:0] v;
    v = 8'h01 << i;
    return ~v;
  endfunction

  initial begin
    logic [2:0] ei;
    logic       ew;
    rst = 1'b1; g = 1'b0; mode = 1'b1; sel = '0; last = 3'd7; dwell = '0;
    rst16 = 1'b1; g16 = 1'b1; mode16 = 1'b0; sel16 = '0; last16 = '0; dwell16 = '0;

    // reset held two cycles, direct sweep, then disable
    vecs.push_back('{1'b1, 1'b0, 1'b1, 3'd0, 3'd7, 8'd0, 8'hFF, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 3'd0, 3'd7, 8'd0, 8'hFF, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd0, 3'd7, 8'd0, 8'hFE, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd1, 3'd7, 8'd0, 8'hFD, 3'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd2, 3'd7, 8'd0, 8'hFB, 3'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd3, 3'd7, 8'd0, 8'hF7, 3'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd4, 3'd7, 8'd0, 8'hEF, 3'd4, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd5, 3'd7, 8'd0, 8'hDF, 3'd5, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd6, 3'd7, 8'd0, 8'hBF, 3'd6, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 8'd0, 8'h7F, 3'd7, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd7, 3'd7, 8'd0, 8'hFF, 3'd0, 1'b0, 1'b0});
    // LAST=0, DWELL=0: entry without WRAP, then WRAP every cycle on index 0
    vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'd0, 8'hFE, 3'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'd0, 8'hFE, 3'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'd0, 8'hFE, 3'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 8'd0, 8'hFE, 3'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 8'd0, 8'hFF, 3'd0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      rst = vecs[i].rst; g = vecs[i].g; mode = vecs[i].mode;
      sel = vecs[i].sel; last = vecs[i].last; dwell = vecs[i].dwell;
      step();
      chk8($sformatf("vec%0d", i), vecs[i].ey, vecs[i].eidx, vecs[i].evalid, vecs[i].ewrap);
    end

    // full sweep LAST=7 DWELL=2: 3 cycles per index, WRAP every 24 cycles
    g = 1'b0; mode = 1'b1; last = 3'd7; dwell = 8'd2;
    for (int t = 0; t < 50; t++) begin
      step();
      ei = 3'((t / 3) % 8);
      ew = (t > 0) && (t % 3 == 0) && (ei == 3'd0);
      chk8($sformatf("sweep_t%0d", t), al8(int'(ei)), ei, 1'b1, ew);
    end
    g = 1'b1; step();
    chk8("sweep_g_off", 8'hFF, 3'd0, 1'b0, 1'b0);

    // dwell change mid-hold applies only at the next reload
    g = 1'b0; mode = 1'b1; last = 3'd7; dwell = 8'd3;
    step(); chk8("dw_t0", 8'hFE, 3'd0, 1'b1, 1'b0);
    dwell = 8'd0;
    step(); chk8("dw_t1", 8'hFE, 3'd0, 1'b1, 1'b0);
    step(); chk8("dw_t2", 8'hFE, 3'd0, 1'b1, 1'b0);
    step(); chk8("dw_t3", 8'hFE, 3'd0, 1'b1, 1'b0);
    step(); chk8("dw_t4", 8'hFD, 3'd1, 1'b1, 1'b0);
    step(); chk8("dw_t5", 8'hFB, 3'd2, 1'b1, 1'b0);
    g = 1'b1; step();

    // LAST lowered below current index: next advance wraps
    g = 1'b0; mode = 1'b1; last = 3'd7; dwell = 8'd0;
    for (int t = 0; t <= 5; t++) begin
      step();
      chk8($sformatf("lastdrop_t%0d", t), al8(t), 3'(t), 1'b1, 1'b0);
    end
    last = 3'd2;
    step(); chk8("lastdrop_wrap", 8'hFE, 3'd0, 1'b1, 1'b1);
    step(); chk8("lastdrop_after", 8'hFD, 3'd1, 1'b1, 1'b0);
    g = 1'b1; step();

    // mode switches and reset mid-scan
    g = 1'b0; mode = 1'b1; last = 3'd7; dwell = 8'd0;
    for (int t = 0; t <= 4; t++) step();
    chk8("mid_idx4", 8'hEF, 3'd4, 1'b1, 1'b0);
    mode = 1'b0; sel = 3'd6;
    step(); chk8("mid_direct6", 8'hBF, 3'd6, 1'b1, 1'b0);
    mode = 1'b1;
    step(); chk8("mid_rescan", 8'hFE, 3'd0, 1'b1, 1'b0);
    step(); step(); step();
    chk8("mid_idx3", 8'hF7, 3'd3, 1'b1, 1'b0);
    rst = 1'b1;
    step(); chk8("mid_rst", 8'hFF, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk8("mid_restart", 8'hFE, 3'd0, 1'b1, 1'b0);
    step(); chk8("mid_restart1", 8'hFD, 3'd1, 1'b1, 1'b0);

    // 4-bit select, active-high outputs
    chk16("w16_reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst16 = 1'b0; g16 = 1'b0; mode16 = 1'b0; sel16 = 4'd9;
    step(); chk16("w16_direct9", 16'h0200, 4'd9, 1'b1, 1'b0);
    mode16 = 1'b1; last16 = 4'd15; dwell16 = 8'd0;
    for (int t = 0; t <= 16; t++) begin
      step();
      chk16($sformatf("w16_scan_t%0d", t), 16'h0001 << (t % 16), 4'(t % 16), 1'b1, t == 16);
    end
    g16 = 1'b1;
    step(); chk16("w16_g_off", 16'h0000, 4'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
